msg_buffer: RTL

//  Parametrised serial message buffer: receives 8N1 UART chars on serial_in, stores them
//  in a DEPTH-entry buffer with backspace editing and a char limit, replays the stored

---
 rtl/msg_buffer_pkg.sv | 29 ++
 rtl/uart_rx_core.sv | 102 ++++++++++
 rtl/msg_buffer.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/msg_buffer_pkg.sv
// Shared constants and state types for the serial message buffer and its UART receiver.
package msg_buffer_pkg;

    localparam int unsigned DATA_W = 8;

    localparam logic [DATA_W-1:0] ASCII_BS  = 8'h08;
    localparam logic [DATA_W-1:0] ASCII_DEL = 8'h7F;
    localparam logic [DATA_W-1:0] ASCII_SP  = 8'h20;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_FETCH,
        ST_SEND,
        ST_WAIT
    } state_e;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_e;

    function automatic logic is_erase(input logic [DATA_W-1:0] c);
        return (c == ASCII_BS) || (c == ASCII_DEL);
    endfunction

endpackage

// File: rtl/uart_rx_core.sv
// 8N1 UART receiver: 2-flop synchroniser, mid-bit sampling, one-cycle valid/framing-error pulses.
module uart_rx_core #(
    parameter int unsigned CLKS_PER_BIT = 5208
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       rxd,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_ferr
);
    import msg_buffer_pkg::*;

    localparam int unsigned CW = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

    logic [2:0]        sync_q;
    rx_state_e         state_q;
    logic [CW-1:0]     cnt_q;
    logic [2:0]        bit_q;
    logic [DATA_W-1:0] data_q;
    logic              valid_q;
    logic              ferr_q;
    logic              rx_s_c;
    logic              fall_c;

    assign rx_s_c = sync_q[1];
    assign fall_c = sync_q[2] & ~sync_q[1];

    // Synchroniser plus one history stage for edge detection; runs even when disabled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= 3'b111;
        end else begin
            sync_q <= {sync_q[1:0], rxd};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RX_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            if (en) begin
                case (state_q)
                    RX_IDLE: begin
                        if (fall_c) begin
                            state_q <= RX_START;
                            cnt_q   <= '0;
                        end
                    end
                    RX_START: begin
                        if (cnt_q == HALF_M1) begin
                            cnt_q   <= '0;
                            bit_q   <= '0;
                            state_q <= rx_s_c ? RX_IDLE : RX_DATA;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                    RX_DATA: begin
                        if (cnt_q == FULL_M1) begin
                            cnt_q  <= '0;
                            data_q <= {rx_s_c, data_q[7:1]};
                            if (bit_q == 3'd7) begin
                                state_q <= RX_STOP;
                            end else begin
                                bit_q <= bit_q + 1'b1;
                            end
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                    RX_STOP: begin
                        if (cnt_q == FULL_M1) begin
                            cnt_q   <= '0;
                            state_q <= RX_IDLE;
                            valid_q <= rx_s_c;
                            ferr_q  <= ~rx_s_c;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                    default: state_q <= RX_IDLE;
                endcase
            end
        end
    end

    assign rx_data  = data_q;
    assign rx_valid = valid_q;
    assign rx_ferr  = ferr_q;

endmodule

// File: rtl/msg_buffer.sv
// Serial message buffer: stores received chars with backspace editing, replays them to the transmitter.
// Define ECHO_EN to add local echo of stored chars and backspace erase sequences.
module msg_buffer
    import msg_buffer_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 5208,
    parameter int unsigned DEPTH        = 256,
    parameter int unsigned MAX_CHARS    = 160,
    parameter int unsigned CNT_W        = $clog2(DEPTH + 1)
) (
    input  logic              sysclk,
    input  logic              reset_n,
    input  logic              active,
    input  logic              clear,
    input  logic              play,
    input  logic              serial_in,
    input  logic              tx_busy,
    output logic [7:0]        tx_data,
    output logic              tx_start,
    output logic [CNT_W-1:0]  count,
    output logic              under_limit,
    output logic              busy,
    output logic              rx_err,
    output logic              rx_drop
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNT_W-1:0] MAX_C    = CNT_W'(MAX_CHARS);
    localparam logic [AW-1:0]    LAST_ADR = AW'(DEPTH - 1);

    logic [DATA_W-1:0] rx_data;
    logic              rx_valid;
    logic              rx_ferr;

    uart_rx_core #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_rx (
        .clk     (sysclk),
        .rst_n   (reset_n),
        .en      (active),
        .rxd     (serial_in),
        .rx_data (rx_data),
        .rx_valid(rx_valid),
        .rx_ferr (rx_ferr)
    );

    state_e            state_q;
    logic              busy_q;
    logic [CNT_W-1:0]  count_q;
    logic              under_limit_q;
    logic [CNT_W-1:0]  idx_q;
    logic [CNT_W-1:0]  n_q;
    logic [AW-1:0]     clr_addr_q;
    logic              seen_q;
    logic [DATA_W-1:0] tx_data_q;
    logic              tx_start_q;
    logic              rx_drop_q;
    logic              rx_err_q;
    logic [DATA_W-1:0] rdata_q;
    logic [DATA_W-1:0] mem [DEPTH];

    logic              is_erase_c;
    logic              echo_free_c;
    logic              send_ok_c;
    logic              store_c;
    logic              erase_c;
    logic              drop_c;
    logic              mem_we_c;
    logic              mem_re_c;
    logic [AW-1:0]     mem_addr_c;
    logic [DATA_W-1:0] mem_wdata_c;

`ifdef ECHO_EN
    logic [1:0]        echo_cnt_q;
    logic [DATA_W-1:0] echo_char_q;
    logic              echo_wait_q;
    logic              echo_seen_q;

    assign echo_free_c = (echo_cnt_q == 2'd0);
    assign send_ok_c   = !tx_busy && !echo_wait_q;
`else
    assign echo_free_c = 1'b1;
    assign send_ok_c   = !tx_busy;
`endif

    // Received-char classification; chars are only consumed while IDLE.
    assign is_erase_c = is_erase(rx_data);
    assign store_c = active && (state_q == ST_IDLE) && rx_valid && !is_erase_c
                     && (count_q < MAX_C) && echo_free_c;
    assign erase_c = active && (state_q == ST_IDLE) && rx_valid && is_erase_c
                     && (count_q != '0) && echo_free_c;
    assign drop_c  = active && rx_valid &&
                     ((state_q != ST_IDLE) ||
                      (!is_erase_c && (count_q >= MAX_C)) ||
                      (!echo_free_c && !(is_erase_c && (count_q == '0))));

    always_comb begin
        mem_we_c    = 1'b0;
        mem_re_c    = 1'b0;
        mem_addr_c  = count_q[AW-1:0];
        mem_wdata_c = rx_data;
        if (active) begin
            if (state_q == ST_CLEAR) begin
                mem_we_c    = 1'b1;
                mem_addr_c  = clr_addr_q;
                mem_wdata_c = '0;
            end else if (store_c) begin
                mem_we_c = 1'b1;
            end else if (state_q == ST_FETCH) begin
                mem_re_c   = 1'b1;
                mem_addr_c = idx_q[AW-1:0];
            end
        end
    end

    // Single-port write-first RAM; contents survive reset.
    always_ff @(posedge sysclk) begin
        if (mem_we_c) begin
            mem[mem_addr_c] <= mem_wdata_c;
            rdata_q         <= mem_wdata_c;
        end else if (mem_re_c) begin
            rdata_q <= mem[mem_addr_c];
        end
    end

    always_ff @(posedge sysclk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= ST_IDLE;
            busy_q        <= 1'b0;
            count_q       <= '0;
            under_limit_q <= 1'b1;
            idx_q         <= '0;
            n_q           <= '0;
            clr_addr_q    <= '0;
            seen_q        <= 1'b0;
            tx_data_q     <= '0;
            tx_start_q    <= 1'b0;
            rx_drop_q     <= 1'b0;
            rx_err_q      <= 1'b0;
`ifdef ECHO_EN
            echo_cnt_q    <= '0;
            echo_char_q   <= '0;
            echo_wait_q   <= 1'b0;
            echo_seen_q   <= 1'b0;
`endif
        end else begin
            tx_start_q <= 1'b0;
            rx_drop_q  <= 1'b0;
            rx_err_q   <= 1'b0;
            if (active) begin
                rx_err_q  <= rx_ferr;
                rx_drop_q <= drop_c;
                if (store_c) begin
                    count_q       <= count_q + 1'b1;
                    under_limit_q <= (count_q + 1'b1) < MAX_C;
                end else if (erase_c) begin
                    count_q       <= count_q - 1'b1;
                    under_limit_q <= 1'b1;
                end

                // A clear in the same cycle as a char overrides the count update above.
                case (state_q)
                    ST_IDLE: begin
                        if (clear) begin
                            state_q       <= ST_CLEAR;
                            busy_q        <= 1'b1;
                            clr_addr_q    <= '0;
                            count_q       <= '0;
                            under_limit_q <= 1'b1;
                        end else if (play && (count_q != '0)) begin
                            state_q <= ST_FETCH;
                            busy_q  <= 1'b1;
                            idx_q   <= '0;
                            n_q     <= count_q;
                        end
                    end
                    ST_CLEAR: begin
                        if (clr_addr_q == LAST_ADR) begin
                            state_q <= ST_IDLE;
                            busy_q  <= 1'b0;
                        end else begin
                            clr_addr_q <= clr_addr_q + 1'b1;
                        end
                    end
                    ST_FETCH: state_q <= ST_SEND;
                    ST_SEND: begin
                        if (send_ok_c) begin
                            tx_data_q  <= rdata_q;
                            tx_start_q <= 1'b1;
                            seen_q     <= 1'b0;
                            state_q    <= ST_WAIT;
                        end
                    end
                    ST_WAIT: begin
                        if (!seen_q) begin
                            seen_q <= tx_busy;
                        end else if (!tx_busy) begin
                            if ((idx_q + 1'b1) == n_q) begin
                                state_q <= ST_IDLE;
                                busy_q  <= 1'b0;
                            end else begin
                                idx_q   <= idx_q + 1'b1;
                                state_q <= ST_FETCH;
                            end
                        end
                    end
                    default: begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end
                endcase

`ifdef ECHO_EN
                // Echo sender: one transfer in flight, waits for the busy rise/fall pair.
                if (echo_wait_q) begin
                    if (!echo_seen_q) begin
                        echo_seen_q <= tx_busy;
                    end else if (!tx_busy) begin
                        echo_wait_q <= 1'b0;
                    end
                end else if ((state_q == ST_IDLE) && (echo_cnt_q != 2'd0) && !tx_busy) begin
                    tx_data_q   <= (echo_cnt_q == 2'd2) ? ASCII_SP : echo_char_q;
                    tx_start_q  <= 1'b1;
                    echo_cnt_q  <= echo_cnt_q - 1'b1;
                    echo_wait_q <= 1'b1;
                    echo_seen_q <= 1'b0;
                end
                if (store_c) begin
                    echo_char_q <= rx_data;
                    echo_cnt_q  <= 2'd1;
                end else if (erase_c) begin
                    echo_char_q <= ASCII_BS;
                    echo_cnt_q  <= 2'd3;
                end
`endif
            end
        end
    end

    assign tx_data     = tx_data_q;
    assign tx_start    = tx_start_q;
    assign count       = count_q;
    assign under_limit = under_limit_q;
    assign busy        = busy_q;
    assign rx_err      = rx_err_q;
    assign rx_drop     = rx_drop_q;

endmodule
